// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LS digit first.
// Latency: start accepted at edge T -> done pulses in the cycle after edge T+DIGITS.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
//
// Optional feature macro: BCD_INVALID_CHECK_EN (adds err output, sticky flag for digits > 9).
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only when busy == 0
//   sub, cin        0: A+B+cin, 1: A-B-borrow (cin acts as borrow-in); latched with start
//   a, b            packed BCD operands, digit0 = [3:0]; latched with start
//   busy            high while digits are being processed
//   done            one-cycle pulse, sum/cout valid
//   sum, cout       packed BCD result (held until next accept); carry-out / no-borrow flag
//   err             (BCD_INVALID_CHECK_EN only) some processed operand digit was > 9
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            sub_q, c_q, cout_q;

  logic            accept;
  logic            last_digit;
  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      t;
  logic            c_nxt;

  assign accept     = start && (state_q != S_RUN);
  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  // Select the digit pair addressed by the counter.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Shared digit adder. Subtraction adds the nine's complement of B; the
  // inverted borrow seeded into the carry completes the ten's complement.
  // Adding 6 modulo 16 is the same as taking (t+6)[3:0].
  always_comb begin
    bd = sub_q ? (4'd9 - b_dig) : b_dig;
    t  = {1'b0, a_dig} + {1'b0, bd} + {4'd0, c_q};
    if (t > 5'd9) begin
      dig   = t[3:0] + 4'd6;
      c_nxt = 1'b1;
    end else begin
      dig   = t[3:0];
      c_nxt = 1'b0;
    end
  end

  // Datapath registers. accept and RUN are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      c_q   <= sub ? ~cin : cin;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cnt_q == CW'(i)) sum_q[4*i +: 4] <= dig;
      end
      c_q <= c_nxt;
      if (last_digit) begin
        cout_q <= c_nxt;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      err_q <= err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: integer reference model, directed + random ops.
// Latency: checks done arrives exactly DIGITS+1 cycles after the accepting edge.
// Backpressure: exercises ignored starts while busy and back-to-back starts in the done cycle.
module tb_bcd_serial_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        chk;   // 0: sum/cout unspecified (invalid digits)
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, cin;
  logic [15:0] a, b, sum;
  logic        busy, done, cout;

  logic        start2, sub2, cin2;
  logic [7:0]  a2, b2, sum2;
  logic        busy2, done2, cout2;

`ifdef BCD_INVALID_CHECK_EN
  logic        err, err2;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef BCD_INVALID_CHECK_EN
    , .err(err)
`endif
  );

  bcd_serial_addsub #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .cin(cin2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef BCD_INVALID_CHECK_EN
    , .err(err2)
`endif
  );

  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x, input int nd);
    logic [15:0] r = '0;
    int          y = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  // Decimal arithmetic on whole numbers, modulo 10^nd.
  function automatic exp_t model(input logic s, input logic c,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 input int nd);
    exp_t e;
    int   m = 10 ** nd;
    int   r;
    if (!s) begin
      r      = bcd2int(av, nd) + bcd2int(bv, nd) + int'(c);
      e.cout = (r >= m);
      r      = r % m;
    end else begin
      r      = bcd2int(av, nd) - bcd2int(bv, nd) - int'(c);
      e.cout = (r >= 0);
      if (r < 0) r = r + m;
    end
    e.sum = int2bcd(r, nd);
    e.err = 1'b0;
    e.chk = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge with busy == 0 (or in the done cycle).
  task automatic send(input logic s, input logic c, input logic [15:0] av, input logic [15:0] bv);
    sub   = s;
    cin   = c;
    a     = av;
    b     = bv;
    start = 1'b1;
    q.push_back(model(s, c, av, bv, 4));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: done timeout, got busy=%0b required done=1", name, busy);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending op");
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          check("sum", 32'(sum), 32'(e.sum));
          check("cout", 32'(cout), 32'(e.cout));
        end
`ifdef BCD_INVALID_CHECK_EN
        check("err", 32'(err), 32'(e.err));
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    exp_t e2;
    start = 0; sub = 0; cin = 0; a = '0; b = '0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Latency / busy width: 1234 + 5678 = 6912
    send(1'b0, 1'b0, 16'h1234, 16'h5678);
    for (int i = 0; i < 4; i++) begin
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    check("lat_busy_end", 32'(busy), 32'd0);
    check("lat_done_end", 32'(done), 32'd1);
    @(negedge clk);
    @(negedge clk);

    // Directed corner cases
    send(1'b0, 1'b1, 16'h9999, 16'h0000); wait_done("ripple"); @(negedge clk);
    send(1'b1, 1'b0, 16'h0500, 16'h0123); wait_done("sub1");   @(negedge clk);
    send(1'b1, 1'b0, 16'h0123, 16'h0500); wait_done("sub2");   @(negedge clk);
    send(1'b1, 1'b1, 16'h0000, 16'h0000); wait_done("sub3");   @(negedge clk);

    // start while busy must be ignored
    send(1'b0, 1'b0, 16'h1234, 16'h5678);
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 16'h9999; b = 16'h8888;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    @(negedge clk);

    // Back-to-back: start during done cycle
    send(1'b0, 1'b1, 16'h0001, 16'h0000);
    wait_done("b2b_first");
    send(1'b0, 1'b0, 16'h0002, 16'h0003);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset during RUN aborts the operation
    send(1'b0, 1'b0, 16'h4321, 16'h1111);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum",  32'(sum),  32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 1'b0, 16'h0456, 16'h0789); wait_done("post_rst"); @(negedge clk);

`ifdef BCD_INVALID_CHECK_EN
    send(1'b0, 1'b0, 16'h12A4, 16'h0000);
    q[q.size()-1].chk = 1'b0;
    q[q.size()-1].err = 1'b1;
    wait_done("inv");
    @(negedge clk);
    send(1'b0, 1'b0, 16'h0011, 16'h0022); wait_done("inv_clear"); @(negedge clk);
`endif

    // Randomised valid-BCD operations with random gaps
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      for (int j = 0; j < 4; j++) begin
        ra[4*j +: 4] = 4'($urandom_range(0, 9));
        rb[4*j +: 4] = 4'($urandom_range(0, 9));
      end
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
      wait_done("rand");
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // DIGITS=2 instance: 99 + 01 and 10 - 25
    for (int k = 0; k < 2; k++) begin
      a2 = (k == 0) ? 8'h99 : 8'h10;
      b2 = (k == 0) ? 8'h01 : 8'h25;
      sub2 = (k == 1);
      cin2 = 1'b0;
      e2 = model(sub2, cin2, {8'h00, a2}, {8'h00, b2}, 2);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("d2_done", 32'(done2), 32'd1);
      check("d2_sum",  32'(sum2),  32'(e2.sum[7:0]));
      check("d2_cout", 32'(cout2), 32'(e2.cout));
`ifdef BCD_INVALID_CHECK_EN
      check("d2_err",  32'(err2),  32'd0);
`endif
      @(negedge clk);
    end

    check("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
